// File: rtl/systolic_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Types and helpers shared by the systolic edge feeder.
//            - feeder_state_t : feeder control states
//            - lane_beat_t    : one lane element with its valid/last flags,
//                               at the mesh's native element width
//            - kw_for()       : width of length/count fields for a K_MAX
// Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // Native mesh element width; lane_beat_t describes one beat at that width.
  localparam int LANE_DATA_WIDTH = 32;

  typedef struct packed {
    logic [LANE_DATA_WIDTH-1:0] data;
    logic                       valid;
    logic                       last;
  } lane_beat_t;

  // Bits needed to hold any value 0..k_max inclusive.
  function automatic int kw_for(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_lane.sv
`default_nettype none
// ============================================================================
// Module   : skew_lane
// Purpose  : DEPTH-stage shift register carrying data plus valid/last flags
//            for one lane of the skewed mesh edge.
// Ports    : clk_i       - clock
//            rstn_i      - asynchronous active-low reset
//            en_i        - shift all stages one step
//            clr_flags_i - clear every valid/last flag, data holds
//            data_i      - element entering stage 0
//            valid_i     - valid flag entering stage 0
//            last_i      - last flag entering stage 0
//            data_o      - element at the final stage
//            valid_o     - valid flag at the final stage
//            last_o      - last flag at the final stage
// Revision : 1.0 - initial release
// ============================================================================
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic                  clr_flags_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o
);

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_last;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int j = 0; j < DEPTH; j++) begin
        r_data[j] <= '0;
      end
      r_valid <= '0;
      r_last  <= '0;
    end else if (clr_flags_i) begin
      // Tile completion: retire the flags but leave the data in place.
      r_valid <= '0;
      r_last  <= '0;
    end else if (en_i) begin
      r_data[0]  <= data_i;
      r_valid[0] <= valid_i;
      r_last[0]  <= last_i;
      for (int j = 1; j < DEPTH; j++) begin
        r_data[j]  <= r_data[j-1];
        r_valid[j] <= r_valid[j-1];
        r_last[j]  <= r_last[j-1];
      end
    end
  end

  assign data_o  = r_data[DEPTH-1];
  assign valid_o = r_valid[DEPTH-1];
  assign last_o  = r_last[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Purpose  : Streaming edge feeder for one side (west or north) of the
//            systolic mesh. Accepts one N-lane vector per beat over a
//            valid/ready handshake and applies the diagonal skew: lane i sees
//            each beat i cycles after lane 0. Signals completion when the
//            final beat leaves lane N-1.
// Ports    : clk_i        - clock
//            rstn_i       - asynchronous active-low reset
//            start_i      - begin a tile (sampled only in IDLE)
//            k_len_i      - beats in the tile, latched with start_i
//            advance_i    - mesh enable; pipeline shifts only when high
//            s_valid_i    - input beat valid
//            s_ready_o    - input beat ready
//            s_data_i     - input beat, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//            lane_data_o  - skewed edge data, same packing
//            lane_valid_o - per-lane valid toward the mesh
//            lane_last_o  - per-lane marker of the final beat of the tile
//            beat_count_o - beats accepted in the current tile
//            busy_o       - tile in progress (FEED, DRAIN, DONE)
//            done_o       - one-cycle completion pulse
//            err_o        - sticky illegal-length flag
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int K_MAX      = 256,
  parameter int KW         = kw_for(K_MAX)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [KW-1:0]           k_len_i,
  input  logic                    advance_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [N*DATA_WIDTH-1:0] s_data_i,
  output logic [N*DATA_WIDTH-1:0] lane_data_o,
  output logic [N-1:0]            lane_valid_o,
  output logic [N-1:0]            lane_last_o,
  output logic [KW-1:0]           beat_count_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [KW-1:0] c_k_max = KW'(K_MAX);
  // Drain-counter value on the (N-1)th draining advance.
  localparam logic [KW-1:0] c_drain_final = KW'((N > 1) ? (N - 2) : 0);
  // A single-lane edge has nothing to drain after the last accept.
  localparam feeder_state_t c_after_feed = (N == 1) ? DONE : DRAIN;

  feeder_state_t r_state;
  feeder_state_t w_next_state;

  logic [KW-1:0] r_k_len;
  logic [KW-1:0] r_beat_cnt;
  logic [KW-1:0] r_drain_cnt;
  logic          r_err;

  logic w_len_ok;
  logic w_accept;
  logic w_last_accept;
  logic w_shift;
  logic w_clr_flags;

  assign w_len_ok      = (k_len_i != '0) && (k_len_i <= c_k_max);
  assign w_accept      = (r_state == FEED) && advance_i && s_valid_i;
  assign w_last_accept = w_accept && (r_beat_cnt == (r_k_len - KW'(1)));

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    s_ready_o    = 1'b0;
    w_shift      = 1'b0;
    w_clr_flags  = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;

    unique case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i && w_len_ok) begin
          w_next_state = FEED;
        end
      end
      FEED: begin
        s_ready_o = advance_i;
        w_shift   = advance_i;
        if (w_last_accept) begin
          w_next_state = c_after_feed;
        end
      end
      DRAIN: begin
        w_shift = advance_i;
        if (advance_i && (r_drain_cnt == c_drain_final)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        // The final beat is visible on lane N-1 during this cycle.
        done_o       = 1'b1;
        w_clr_flags  = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, tile length and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          r_drain_cnt <= '0;
          if (start_i) begin
            if (w_len_ok) begin
              r_k_len    <= k_len_i;
              r_beat_cnt <= '0;
              r_err      <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FEED: begin
          r_drain_cnt <= '0;
          // Saturate at the tile length rather than wrapping.
          if (w_accept && (r_beat_cnt != r_k_len)) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
          end
        end
        DRAIN: begin
          if (advance_i) begin
            r_drain_cnt <= r_drain_cnt + KW'(1);
          end
        end
        default: begin
          r_drain_cnt <= r_drain_cnt;
        end
      endcase
    end
  end

  assign beat_count_o = r_beat_cnt;
  assign err_o        = r_err;

  // --------------------------------------------------------------------------
  // Skew pipeline: lane i is i+1 stages deep, so a beat accepted on one edge
  // reaches lane i after i further advancing edges. Bubbles (valid=0) enter
  // every lane on advancing edges without an accept.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_lane #(
      .DEPTH      (gi + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .en_i        (w_shift),
      .clr_flags_i (w_clr_flags),
      .data_i      (s_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .valid_i     (w_accept),
      .last_i      (w_last_accept),
      .data_o      (lane_data_o[gi*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o     (lane_valid_o[gi]),
      .last_o      (lane_last_o[gi])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Purpose  : Directed self-checking bench for systolic_skew_feeder with a
//            4-lane instance and a 1-lane instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

  localparam int DW = 16;
  localparam int KW = 9;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // 4-lane instance
  logic            start4 = 1'b0;
  logic [KW-1:0]   k4     = '0;
  logic            adv4   = 1'b0;
  logic            vld4   = 1'b0;
  logic            rdy4;
  logic [4*DW-1:0] din4   = '0;
  logic [4*DW-1:0] dout4;
  logic [3:0]      lv4, ll4;
  logic [KW-1:0]   bc4;
  logic            busy4, done4, err4;

  // 1-lane instance
  logic            start1 = 1'b0;
  logic [KW-1:0]   k1     = '0;
  logic            adv1   = 1'b0;
  logic            vld1   = 1'b0;
  logic            rdy1;
  logic [DW-1:0]   din1   = '0;
  logic [DW-1:0]   dout1;
  logic [0:0]      lv1, ll1;
  logic [KW-1:0]   bc1;
  logic            busy1, done1, err1;

  systolic_skew_feeder #(.N(4), .DATA_WIDTH(DW), .K_MAX(256)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start4), .k_len_i(k4),
    .advance_i(adv4), .s_valid_i(vld4), .s_ready_o(rdy4), .s_data_i(din4),
    .lane_data_o(dout4), .lane_valid_o(lv4), .lane_last_o(ll4),
    .beat_count_o(bc4), .busy_o(busy4), .done_o(done4), .err_o(err4)
  );

  systolic_skew_feeder #(.N(1), .DATA_WIDTH(DW), .K_MAX(256)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start1), .k_len_i(k1),
    .advance_i(adv1), .s_valid_i(vld1), .s_ready_o(rdy1), .s_data_i(din1),
    .lane_data_o(dout1), .lane_valid_o(lv1), .lane_last_o(ll1),
    .beat_count_o(bc1), .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [4*DW-1:0] mk4(input int b);
    logic [4*DW-1:0] v;
    for (int i = 0; i < 4; i++) v[i*DW +: DW] = DW'(10 * b + i);
    return v;
  endfunction

  // Per-cycle stimulus (index = cycle in which the input is presented) and
  // expected outputs (index = cycle after the edge). Cycle 0 follows start.
  logic adv_pat[12];
  logic vld_pat[12];
  int   e_rdy[12];
  int   e_v0[12], e_d0[12], e_l0[12];
  int   e_v3[12], e_d3[12], e_l3[12];
  int   e_done[12];

  task automatic run4(input string tag, input int k, input int last_cyc);
    int beat;
    beat   = 0;
    start4 = 1'b1; k4 = KW'(k); adv4 = 1'b1; vld4 = 1'b0;
    tick();
    start4 = 1'b0;
    for (int c = 0; c <= last_cyc; c++) begin
      if (c == 0) begin
        check_eq({tag, ".err_clear"}, err4, 0);
        check_eq({tag, ".busy"}, busy4, 1);
      end else begin
        check_eq($sformatf("%s.c%0d.v0", tag, c), lv4[0], e_v0[c]);
        if (e_v0[c] == 1) check_eq($sformatf("%s.c%0d.d0", tag, c), dout4[DW-1:0], e_d0[c]);
        check_eq($sformatf("%s.c%0d.l0", tag, c), ll4[0], e_l0[c]);
        check_eq($sformatf("%s.c%0d.v3", tag, c), lv4[3], e_v3[c]);
        if (e_v3[c] == 1) check_eq($sformatf("%s.c%0d.d3", tag, c), dout4[4*DW-1 -: DW], e_d3[c]);
        check_eq($sformatf("%s.c%0d.l3", tag, c), ll4[3], e_l3[c]);
        check_eq($sformatf("%s.c%0d.done", tag, c), done4, e_done[c]);
      end
      if (c < last_cyc) begin
        adv4 = adv_pat[c];
        vld4 = vld_pat[c];
        din4 = mk4(beat);
        #1;
        check_eq($sformatf("%s.c%0d.rdy", tag, c), rdy4, e_rdy[c]);
        if (rdy4 && vld4) beat++;
        tick();
      end
    end
    check_eq({tag, ".idle"}, busy4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int beat;

    // ---------------- reset state ----------------
    adv4 = 1'b1; adv1 = 1'b1;
    #12;
    check_eq("rst.data",  dout4, 0);
    check_eq("rst.valid", lv4, 0);
    check_eq("rst.last",  ll4, 0);
    check_eq("rst.busy",  busy4, 0);
    check_eq("rst.ready", rdy4, 0);
    check_eq("rst.done",  done4, 0);
    check_eq("rst.err",   err4, 0);
    check_eq("rst.count", bc4, 0);
    check_eq("rst.v1",    lv1, 0);
    tick();
    rstn = 1'b1;
    tick();

    // ---------------- k=3, free running ----------------
    adv_pat = '{1,1,1,1,1,1,1,1,1,1,1,1};
    vld_pat = '{1,1,1,1,1,1,1,1,1,1,1,1};
    e_rdy   = '{1,1,1,0,0,0,0,0,0,0,0,0};
    e_v0    = '{0,1,1,1,0,0,0,0,0,0,0,0};
    e_d0    = '{0,0,10,20,0,0,0,0,0,0,0,0};
    e_l0    = '{0,0,0,1,0,0,0,0,0,0,0,0};
    e_v3    = '{0,0,0,0,1,1,1,0,0,0,0,0};
    e_d3    = '{0,0,0,0,3,13,23,0,0,0,0,0};
    e_l3    = '{0,0,0,0,0,0,1,0,0,0,0,0};
    e_done  = '{0,0,0,0,0,0,1,0,0,0,0,0};
    run4("t1", 3, 7);
    check_eq("t1.count", bc4, 3);

    // ---------------- k=3, two-cycle stall mid-feed ----------------
    adv_pat = '{1,1,0,0,1,1,1,1,1,1,1,1};
    e_rdy   = '{1,1,0,0,1,0,0,0,0,0,0,0};
    e_v0    = '{0,1,1,1,1,1,0,0,0,0,0,0};
    e_d0    = '{0,0,10,10,10,20,0,0,0,0,0,0};
    e_l0    = '{0,0,0,0,0,1,0,0,0,0,0,0};
    e_v3    = '{0,0,0,0,0,0,1,1,1,0,0,0};
    e_d3    = '{0,0,0,0,0,0,3,13,23,0,0,0};
    e_l3    = '{0,0,0,0,0,0,0,0,1,0,0,0};
    e_done  = '{0,0,0,0,0,0,0,0,1,0,0,0};
    run4("t2", 3, 9);
    check_eq("t2.count", bc4, 3);

    // ---------------- k=3, one-cycle input bubble ----------------
    adv_pat = '{1,1,1,1,1,1,1,1,1,1,1,1};
    vld_pat = '{1,0,1,1,1,1,1,1,1,1,1,1};
    e_rdy   = '{1,1,1,1,0,0,0,0,0,0,0,0};
    e_v0    = '{0,1,0,1,1,0,0,0,0,0,0,0};
    e_d0    = '{0,0,0,10,20,0,0,0,0,0,0,0};
    e_l0    = '{0,0,0,0,1,0,0,0,0,0,0,0};
    e_v3    = '{0,0,0,0,1,0,1,1,0,0,0,0};
    e_d3    = '{0,0,0,0,3,0,13,23,0,0,0,0};
    e_l3    = '{0,0,0,0,0,0,0,1,0,0,0,0};
    e_done  = '{0,0,0,0,0,0,0,1,0,0,0,0};
    run4("t3", 3, 8);
    check_eq("t3.count", bc4, 3);

    // ---------------- illegal lengths, then k=2 ----------------
    start4 = 1'b1; k4 = KW'(257); adv4 = 1'b1; vld4 = 1'b1;
    tick();
    start4 = 1'b0;
    #1;
    check_eq("t4.err_kmax1", err4, 1);
    check_eq("t4.busy_kmax1", busy4, 0);
    check_eq("t4.rdy_kmax1", rdy4, 0);
    start4 = 1'b1; k4 = '0;
    tick();
    start4 = 1'b0;
    #1;
    check_eq("t4.err_zero", err4, 1);
    check_eq("t4.busy_zero", busy4, 0);
    check_eq("t4.rdy_zero", rdy4, 0);
    vld_pat = '{1,1,1,1,1,1,1,1,1,1,1,1};
    e_rdy   = '{1,1,0,0,0,0,0,0,0,0,0,0};
    e_v0    = '{0,1,1,0,0,0,0,0,0,0,0,0};
    e_d0    = '{0,0,10,0,0,0,0,0,0,0,0,0};
    e_l0    = '{0,0,1,0,0,0,0,0,0,0,0,0};
    e_v3    = '{0,0,0,0,1,1,0,0,0,0,0,0};
    e_d3    = '{0,0,0,0,3,13,0,0,0,0,0,0};
    e_l3    = '{0,0,0,0,0,1,0,0,0,0,0,0};
    e_done  = '{0,0,0,0,0,1,0,0,0,0,0,0};
    run4("t4", 2, 6);
    check_eq("t4.count", bc4, 2);

    // ---------------- reset asserted during DRAIN ----------------
    start4 = 1'b1; k4 = KW'(3); adv4 = 1'b1; vld4 = 1'b0;
    tick();
    start4 = 1'b0;
    beat = 0;
    for (int c = 0; c < 4; c++) begin
      vld4 = 1'b1; din4 = mk4(beat);
      #1;
      if (rdy4) beat++;
      tick();
    end
    check_eq("t5.pre_busy", busy4, 1);
    check_eq("t5.pre_v3", lv4[3], 1);
    #1 rstn = 1'b0;
    #1;
    check_eq("t5.rst_data",  dout4, 0);
    check_eq("t5.rst_valid", lv4, 0);
    check_eq("t5.rst_last",  ll4, 0);
    check_eq("t5.rst_count", bc4, 0);
    check_eq("t5.rst_busy",  busy4, 0);
    check_eq("t5.rst_ready", rdy4, 0);
    check_eq("t5.rst_err",   err4, 0);
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("t5.rst_done%0d", c), done4, 0);
      tick();
    end
    rstn = 1'b1;
    tick();
    e_rdy   = '{1,0,0,0,0,0,0,0,0,0,0,0};
    e_v0    = '{0,1,0,0,0,0,0,0,0,0,0,0};
    e_d0    = '{0,0,0,0,0,0,0,0,0,0,0,0};
    e_l0    = '{0,1,0,0,0,0,0,0,0,0,0,0};
    e_v3    = '{0,0,0,0,1,0,0,0,0,0,0,0};
    e_d3    = '{0,0,0,0,3,0,0,0,0,0,0,0};
    e_l3    = '{0,0,0,0,1,0,0,0,0,0,0,0};
    e_done  = '{0,0,0,0,1,0,0,0,0,0,0,0};
    run4("t5", 1, 5);

    // ---------------- single lane, k=5 ----------------
    start1 = 1'b1; k1 = KW'(5); adv1 = 1'b1; vld1 = 1'b0;
    tick();
    start1 = 1'b0;
    beat = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c >= 1) begin
        check_eq($sformatf("t6.c%0d.v", c), lv1, 1);
        check_eq($sformatf("t6.c%0d.d", c), dout1, 10 * (c - 1));
        check_eq($sformatf("t6.c%0d.l", c), ll1, (c == 5) ? 1 : 0);
        check_eq($sformatf("t6.c%0d.done", c), done1, (c == 5) ? 1 : 0);
        check_eq($sformatf("t6.c%0d.busy", c), busy1, 1);
      end
      if (c < 5) begin
        vld1 = 1'b1; din1 = DW'(10 * beat);
        #1;
        check_eq($sformatf("t6.c%0d.rdy", c), rdy1, 1);
        if (rdy1 && vld1) beat++;
        tick();
      end
    end
    #1;
    check_eq("t6.ready_after_last", rdy1, 0);
    tick();
    check_eq("t6.idle_busy", busy1, 0);
    check_eq("t6.idle_done", done1, 0);
    check_eq("t6.idle_v", lv1, 0);
    check_eq("t6.count", bc1, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
